// File: rtl/load_buffer_tracker.sv
// rtl/load_buffer_tracker.sv - outstanding-load slot tracker with registered writeback
// Optional feature macro: LOAD_BUFFER_SAME_CYCLE_REUSE_EN (reallocate a response-freed slot in the same cycle while full)
module load_buffer_tracker #(
  parameter int unsigned NR_ENTRIES    = 2,
  parameter int unsigned TRANS_ID_BITS = 3,
  parameter int unsigned XLEN          = 32,
  parameter int unsigned META_W        = 5,
  localparam int unsigned IDX_W        = (NR_ENTRIES > 1) ? $clog2(NR_ENTRIES) : 1
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     flush_i,
  input  logic                     req_valid_i,
  output logic                     req_ready_o,
  input  logic [TRANS_ID_BITS-1:0] req_trans_id_i,
  input  logic [META_W-1:0]        req_meta_i,
  output logic [IDX_W-1:0]         req_tag_o,
  input  logic                     rsp_valid_i,
  input  logic [IDX_W-1:0]         rsp_tag_i,
  input  logic [XLEN-1:0]          rsp_data_i,
  output logic                     out_valid_o,
  output logic [TRANS_ID_BITS-1:0] out_trans_id_o,
  output logic [META_W-1:0]        out_meta_o,
  output logic [XLEN-1:0]          out_data_o,
  output logic                     empty_o,
  output logic                     full_o
);

  logic [NR_ENTRIES-1:0]    valid_q, valid_d;
  logic [NR_ENTRIES-1:0]    killed_q, killed_d;
  logic [TRANS_ID_BITS-1:0] trans_id_q [NR_ENTRIES];
  logic [TRANS_ID_BITS-1:0] trans_id_d [NR_ENTRIES];
  logic [META_W-1:0]        meta_q [NR_ENTRIES];
  logic [META_W-1:0]        meta_d [NR_ENTRIES];

  logic                     out_valid_q, out_valid_d;
  logic [TRANS_ID_BITS-1:0] out_trans_id_q, out_trans_id_d;
  logic [META_W-1:0]        out_meta_q, out_meta_d;
  logic [XLEN-1:0]          out_data_q, out_data_d;

  logic [NR_ENTRIES-1:0]    rsp_sel;
  logic                     rsp_hit;
  logic                     rsp_killed;
  logic [TRANS_ID_BITS-1:0] rsp_trans_id;
  logic [META_W-1:0]        rsp_meta;
  logic                     has_free;
  logic [IDX_W-1:0]         free_idx;
  logic                     reuse;
  logic [IDX_W-1:0]         alloc_idx;
  logic                     req_ready;
  logic                     req_fire;

  // Decode the response slot; tags beyond NR_ENTRIES or to free slots select nothing.
  always_comb begin
    rsp_sel      = '0;
    rsp_killed   = 1'b0;
    rsp_trans_id = '0;
    rsp_meta     = '0;
    for (int i = 0; i < int'(NR_ENTRIES); i++) begin
      if (rsp_valid_i && valid_q[i] && (rsp_tag_i == IDX_W'(i))) begin
        rsp_sel[i]   = 1'b1;
        rsp_killed   = killed_q[i];
        rsp_trans_id = trans_id_q[i];
        rsp_meta     = meta_q[i];
      end
    end
    rsp_hit = |rsp_sel;
  end

  // Pick the lowest-index free slot and form the issue handshake.
  always_comb begin
    has_free = 1'b0;
    free_idx = '0;
    for (int i = int'(NR_ENTRIES) - 1; i >= 0; i--) begin
      if (!valid_q[i]) begin
        has_free = 1'b1;
        free_idx = IDX_W'(i);
      end
    end
`ifdef LOAD_BUFFER_SAME_CYCLE_REUSE_EN
    reuse     = !has_free && rsp_hit;
    alloc_idx = has_free ? free_idx : rsp_tag_i;
`else
    reuse     = 1'b0;
    alloc_idx = free_idx;
`endif
    req_ready = (has_free || reuse) && !flush_i;
    req_fire  = req_valid_i && req_ready;
  end

  // Slot and writeback next state; allocation wins over a same-cycle free of the same slot.
  always_comb begin
    valid_d    = valid_q;
    killed_d   = killed_q;
    trans_id_d = trans_id_q;
    meta_d     = meta_q;
    for (int i = 0; i < int'(NR_ENTRIES); i++) begin
      if (rsp_sel[i]) valid_d[i] = 1'b0;
      if (flush_i && valid_q[i]) killed_d[i] = 1'b1;
      if (req_fire && (alloc_idx == IDX_W'(i))) begin
        valid_d[i]    = 1'b1;
        killed_d[i]   = 1'b0;
        trans_id_d[i] = req_trans_id_i;
        meta_d[i]     = req_meta_i;
      end
    end
    // A response landing in the flush cycle counts as killed, so nothing is written back post-flush.
    out_valid_d    = rsp_hit && !rsp_killed && !flush_i;
    out_trans_id_d = out_trans_id_q;
    out_meta_d     = out_meta_q;
    out_data_d     = out_data_q;
    if (out_valid_d) begin
      out_trans_id_d = rsp_trans_id;
      out_meta_d     = rsp_meta;
      out_data_d     = rsp_data_i;
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q        <= '0;
      killed_q       <= '0;
      for (int i = 0; i < int'(NR_ENTRIES); i++) begin
        trans_id_q[i] <= '0;
        meta_q[i]     <= '0;
      end
      out_valid_q    <= 1'b0;
      out_trans_id_q <= '0;
      out_meta_q     <= '0;
      out_data_q     <= '0;
    end else begin
      valid_q        <= valid_d;
      killed_q       <= killed_d;
      trans_id_q     <= trans_id_d;
      meta_q         <= meta_d;
      out_valid_q    <= out_valid_d;
      out_trans_id_q <= out_trans_id_d;
      out_meta_q     <= out_meta_d;
      out_data_q     <= out_data_d;
    end
  end

  assign req_ready_o    = req_ready;
  assign req_tag_o      = alloc_idx;
  assign out_valid_o    = out_valid_q;
  assign out_trans_id_o = out_trans_id_q;
  assign out_meta_o     = out_meta_q;
  assign out_data_o     = out_data_q;
  assign empty_o        = ~|valid_q;
  assign full_o         = &valid_q;

endmodule

// File: doc/load_buffer_tracker.md
LOAD_BUFFER_TRACKER -- requirements
Module: load_buffer_tracker

Interface
REQ-001 SHALL have parameter NR_ENTRIES, default 2: number of outstanding-load slots (1..8).
REQ-002 SHALL have parameter TRANS_ID_BITS, default 3: scoreboard transaction-ID width.
REQ-003 SHALL have parameter XLEN, default 32: load data width.
REQ-004 SHALL have parameter META_W, default 5: per-load metadata width (byte offset, size, sign).
REQ-005 SHALL define IDX_W = max(1, clog2(NR_ENTRIES)).
REQ-006 SHALL have ports clk_i in 1 (clock) and rst_ni in 1 (reset); one clock; reset is asynchronous and active-low.
REQ-007 SHALL have port flush_i in 1: kill all outstanding loads.
REQ-008 SHALL have ports req_valid_i in 1, req_ready_o out 1: load-issue handshake.
REQ-009 SHALL have ports req_trans_id_i in TRANS_ID_BITS and req_meta_i in META_W: attributes of the issued load.
REQ-010 SHALL have port req_tag_o out IDX_W: slot allocated to the request; used as the memory-side ID.
REQ-011 SHALL have ports rsp_valid_i in 1, rsp_tag_i in IDX_W, rsp_data_i in XLEN: memory response.
REQ-012 SHALL have ports out_valid_o out 1, out_trans_id_o out TRANS_ID_BITS, out_meta_o out META_W, out_data_o out XLEN: writeback.
REQ-013 SHALL have ports empty_o out 1 (no slot allocated) and full_o out 1 (all slots allocated).

Function
REQ-014 SHALL hold per slot: valid, killed, trans_id, meta.
REQ-015 SHALL drive req_tag_o combinationally as the lowest-index free slot.
REQ-016 SHALL drive req_ready_o = 1 iff a free slot exists at cycle start and flush_i = 0.
REQ-017 SHALL, on req_valid_i && req_ready_o, set the slot valid, clear killed, and store trans_id/meta at the clock edge.
REQ-018 SHALL, on rsp_valid_i for a valid slot, free that slot at the same edge.
REQ-019 SHALL register the writeback: out_valid_o asserts exactly 1 cycle after rsp_valid_i if the slot was valid and not killed; trans_id/meta come from the slot and data = rsp_data_i.
REQ-020 SHALL deassert out_valid_o in every cycle that follows no qualifying response; writeback SHALL have no backpressure.
REQ-021 SHALL ignore rsp_valid_i to an unallocated slot: no state change and no out_valid_o.
REQ-022 SHALL, on flush_i, set killed on every slot valid at cycle start; killed slots stay allocated until their response arrives, then free silently.
REQ-023 SHALL treat a response arriving in the flush cycle as killed: slot freed, out_valid_o = 0 next cycle.
REQ-024 SHALL also suppress an out_valid_o already scheduled for the cycle after flush_i, so no writeback is emitted post-flush.
REQ-025 SHALL drive empty_o/full_o combinationally from the current slot-valid vector.

Reset
REQ-026 SHALL, while rst_ni = 0, asynchronously clear all slot valid/killed bits and out_valid_o; out_trans_id_o/out_meta_o/out_data_o reset to 0.
REQ-027 SHALL reset empty_o = 1, full_o = 0, req_ready_o = 1 (when flush_i = 0), and req_tag_o = 0.
REQ-028 SHALL discard all in-flight state on reset mid-operation; later responses to pre-reset tags are ignored per REQ-021.

Configuration
REQ-029 SHALL honour macro LOAD_BUFFER_SAME_CYCLE_REUSE_EN.
REQ-030 SHALL, when it is defined, raise req_ready_o while full if rsp_valid_i frees a valid slot this cycle, and allocate that freed slot (req_tag_o = rsp_tag_i) to the new request.
REQ-031 SHALL, when it is undefined, behave exactly per REQ-016 (ready only with a free slot at cycle start).

Verification
REQ-032 Reset: rst_ni = 0 then 1 -> empty_o = 1, full_o = 0, req_ready_o = 1, req_tag_o = 0, out_valid_o = 0.
REQ-033 Two loads, trans_id 3 then 5 -> tags 0 then 1, full_o = 1, req_ready_o = 0; response tag 1 with data 0xDEADBEEF -> next cycle out_valid_o = 1, out_trans_id_o = 5, out_data_o = 0xDEADBEEF.
REQ-034 Two slots live, flush_i pulse, then responses on tags 0 and 1 -> out_valid_o never asserts; empty_o = 1 after the second response.
REQ-035 Full, rsp_valid_i tag 0 plus req_valid_i in the same cycle -> with macro: accepted, req_tag_o = 0; without macro: req_ready_o = 0, accepted on the next cycle.
REQ-036 Response to an empty slot (rsp_tag_i = 1, nothing allocated) -> no out_valid_o, empty_o stays 1.
